arcade_input_ctrl: RTL and testbench
====================================

Name: arcade_input_ctrl

Overview:
- Parametrised player-input front end between hps_io (ps2_key, joystick_N) and the core's joystick ports.
- Supersedes the per-key regs and per-player OR logic in the core top level: N players, M buttons, extended-scancode aware.
- Registered outputs; coin-pulse stretching so short coin presses always reach the game CPU.
- Single clock domain (clk_sys).

Parameters:
- PLAYERS, 2, number of players (1..4); keyboard map exists for players 0 and 1 only.
- BUTTONS, 3, action buttons per player (1..6).
- COIN_CYCLES, 500000, coin output pulse width in clock cycles (min 1, 24-bit counter).

Ports:
- clock  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scancode.
- joystick  in  32*PLAYERS  player p at [32p+31:32p]. Bit map: 0 right, 1 left, 2 down, 3 up, 4+k button k, 4+B start, 5+B coin, 6+B pause, 7+B service (B = BUTTONS).
- up, down, left, right  out  PLAYERS  direction per player.
- buttons  out  BUTTONS*PLAYERS  player p at [B*p+B-1:B*p].
- start, coin, pause, service  out  PLAYERS  per-player controls; coin is stretched.

Behaviour:
- Reset:
  - All key-state regs, outputs and coin counters are 0.
  - toggle_q loads ps2_key[10], so no event is decoded from reset release.
- Key event:
  - An event occurs on a cycle where ps2_key[10] != toggle_q and reset is low.
  - toggle_q updates every cycle.
  - On an event, the matching key reg is written with ps2_key[9] at that edge. Unmatched codes are ignored.
- Key map (E = extended required; X = either extended value matches; otherwise non-extended only):
  - P0: up 75E, down 72E, left 6BE, right 74E, buttons ctrl 14X, alt 11X, space 29, lshift 12, z 1A, x 22; start 1 16, coin 5 2E, pause p 4D, service 9 46.
  - P1: up r 2D, down f 2B, left d 23, right g 34, buttons a 1C, s 1B, q 15, w 1D, e 24, t 2C; start 2 1E, coin 6 36, pause none, service 0 45.
  - Buttons k >= BUTTONS are not decoded.
- Merge: raw = key_reg | joystick bit. Output register <= raw every cycle (except coin).
  - Latency: joystick to output 1 cycle; ps2 event to output 2 cycles.
  - Keyboard and joystick for the same control are independent; release of one does not clear the other.
- Coin stretch, per player:
  - coin_raw_q registered. A rising edge (raw & ~raw_q) loads cnt = COIN_CYCLES. Otherwise, if cnt != 0, decrement.
  - coin output = (cnt != 0), registered.
  - A rising edge while counting reloads (retrigger). Holding raw high does not extend the pulse beyond COIN_CYCLES after the rising edge.
  - Counter saturates at 0, never wraps.
- Reset mid-operation: counters and key regs clear in the same edge; a pulse in flight is truncated.
- Reset has priority over a simultaneous event or coin edge.
- Unused joystick bits (>7+B) are ignored.

Optional Feature:
- Macro AUTOFIRE_EN.
- Defined:
  - Adds input autofire_mask (BUTTONS*PLAYERS) and parameter AUTOFIRE_DIV (default 200000).
  - A free-running divider toggles phase every AUTOFIRE_DIV cycles; phase resets to 0.
  - A masked button output is raw & phase; unmasked buttons pass through.
  - Phase is shared across all players.
- Undefined: no port, no divider; buttons equal raw.

Test Plan:
- Reset release with ps2_key[10]=1 held -> no key regs set; all outputs 0 for 10 cycles.
- Toggle ps2_key[10] with {pressed=1, ext=1, code=75} -> up[0]=1 exactly 2 cycles later. Same with ext=0 -> up[0] stays 0.
- joystick[32+4]=1 (PLAYERS=2) -> buttons[B]=1 after 1 cycle. Press key a via ps2, drop joystick -> buttons[B] stays 1 until the a-release event.
- COIN_CYCLES=8, single-cycle joystick coin pulse -> coin[0] high exactly 8 cycles. Second edge at cycle 5 -> high until cycle 13. Reset at cycle 3 -> coin low the next cycle.
- PLAYERS=4, BUTTONS=6: ps2 event code 1C -> buttons[6] set; players 2,3 respond to joystick only; t (2C) -> buttons[11].
- AUTOFIRE_EN, AUTOFIRE_DIV=4, mask bit 0 set, button held -> buttons[0] toggles every 4 cycles. Unmasked button 1 held -> steady 1.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 key events and hps_io joysticks per player.
// Define AUTOFIRE_EN to add per-button autofire gated by a shared phase.
module arcade_input_ctrl #(
  parameter int PLAYERS     = 2,
  parameter int BUTTONS     = 3,
  parameter int COIN_CYCLES = 500000
`ifdef AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_DIV = 200000
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [32*PLAYERS-1:0]        joystick,
`ifdef AUTOFIRE_EN
  input  logic [BUTTONS*PLAYERS-1:0]   autofire_mask,
`endif
  output logic [PLAYERS-1:0]           up,
  output logic [PLAYERS-1:0]           down,
  output logic [PLAYERS-1:0]           left,
  output logic [PLAYERS-1:0]           right,
  output logic [BUTTONS*PLAYERS-1:0]   buttons,
  output logic [PLAYERS-1:0]           start,
  output logic [PLAYERS-1:0]           coin,
  output logic [PLAYERS-1:0]           pause,
  output logic [PLAYERS-1:0]           service
);

  localparam int KW = 8 + BUTTONS;
  localparam int KP = (PLAYERS > 1) ? 2 : 1;
  localparam int CI = 5 + BUTTONS;
  localparam logic [23:0] COIN_LOAD = 24'(COIN_CYCLES);

  logic [7:0]                   code;
  logic                         ext;
  logic                         toggle_q, toggle_d;
  logic                         evt;
  logic [1:0][13:0]             sel;
  logic [KP-1:0][KW-1:0]        key_q, key_d;
  logic [PLAYERS-1:0][KW-1:0]   key_all;
  logic [PLAYERS-1:0][KW-1:0]   raw;
  logic [PLAYERS-1:0]           coin_raw_q, coin_raw_d;
  logic [PLAYERS-1:0][23:0]     cnt_q, cnt_d;
  logic [PLAYERS-1:0][KW-1:0]   out_q, out_d;
  logic [PLAYERS-1:0]           unused_joy;
  logic                         unused_sel;

  assign code     = ps2_key[7:0];
  assign ext      = ps2_key[8];
  assign toggle_d = ps2_key[10];
  assign evt      = (ps2_key[10] != toggle_q) && !reset;

  // sel layout: [3:0] R/L/D/U, [9:4] buttons 0-5, [13:10] start/coin/pause/service
  always_comb begin
    sel = '0;
    unique case (1'b1)
      (code == 8'h75) &&  ext: sel[0][3]  = 1'b1;
      (code == 8'h72) &&  ext: sel[0][2]  = 1'b1;
      (code == 8'h6B) &&  ext: sel[0][1]  = 1'b1;
      (code == 8'h74) &&  ext: sel[0][0]  = 1'b1;
      (code == 8'h14):         sel[0][4]  = 1'b1;
      (code == 8'h11):         sel[0][5]  = 1'b1;
      (code == 8'h29) && !ext: sel[0][6]  = 1'b1;
      (code == 8'h12) && !ext: sel[0][7]  = 1'b1;
      (code == 8'h1A) && !ext: sel[0][8]  = 1'b1;
      (code == 8'h22) && !ext: sel[0][9]  = 1'b1;
      (code == 8'h16) && !ext: sel[0][10] = 1'b1;
      (code == 8'h2E) && !ext: sel[0][11] = 1'b1;
      (code == 8'h4D) && !ext: sel[0][12] = 1'b1;
      (code == 8'h46) && !ext: sel[0][13] = 1'b1;
      (code == 8'h2D) && !ext: sel[1][3]  = 1'b1;
      (code == 8'h2B) && !ext: sel[1][2]  = 1'b1;
      (code == 8'h23) && !ext: sel[1][1]  = 1'b1;
      (code == 8'h34) && !ext: sel[1][0]  = 1'b1;
      (code == 8'h1C) && !ext: sel[1][4]  = 1'b1;
      (code == 8'h1B) && !ext: sel[1][5]  = 1'b1;
      (code == 8'h15) && !ext: sel[1][6]  = 1'b1;
      (code == 8'h1D) && !ext: sel[1][7]  = 1'b1;
      (code == 8'h24) && !ext: sel[1][8]  = 1'b1;
      (code == 8'h2C) && !ext: sel[1][9]  = 1'b1;
      (code == 8'h1E) && !ext: sel[1][10] = 1'b1;
      (code == 8'h36) && !ext: sel[1][11] = 1'b1;
      (code == 8'h45) && !ext: sel[1][13] = 1'b1;
      default: ;
    endcase
  end

  assign unused_sel = ^sel;

  always_comb begin
    key_d = key_q;
    for (int p = 0; p < KP; p++) begin
      for (int i = 0; i < 4; i++)
        if (evt && sel[p][i])
          key_d[p][i] = ps2_key[9];
      for (int k = 0; k < BUTTONS; k++)
        if (evt && sel[p][4+k])
          key_d[p][4+k] = ps2_key[9];
      for (int j = 0; j < 4; j++)
        if (evt && sel[p][10+j])
          key_d[p][4+BUTTONS+j] = ps2_key[9];
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_raw
    if (p < KP) begin : g_kb
      assign key_all[p] = key_q[p];
    end else begin : g_nokb
      assign key_all[p] = '0;
    end
    assign raw[p] = joystick[32*p +: KW] | key_all[p];
    assign unused_joy[p] = ^joystick[32*p+KW +: 32-KW];
  end

`ifdef AUTOFIRE_EN
  logic [31:0] div_q, div_d;
  logic        phase_q, phase_d;

  always_comb begin
    div_d   = div_q + 32'd1;
    phase_d = phase_q;
    if (div_q == 32'(AUTOFIRE_DIV - 1)) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end
`endif

  // coin counter reloads on every rising edge; output tracks the next count
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      coin_raw_d[p] = raw[p][CI];
      if (coin_raw_d[p] && !coin_raw_q[p])
        cnt_d[p] = COIN_LOAD;
      else if (cnt_q[p] != 24'd0)
        cnt_d[p] = cnt_q[p] - 24'd1;
      else
        cnt_d[p] = cnt_q[p];
      out_d[p]     = raw[p];
      out_d[p][CI] = (cnt_d[p] != 24'd0);
`ifdef AUTOFIRE_EN
      for (int k = 0; k < BUTTONS; k++)
        if (autofire_mask[BUTTONS*p+k])
          out_d[p][4+k] = raw[p][4+k] & phase_q;
`endif
    end
  end

  always_ff @(posedge clock) begin
    toggle_q <= toggle_d;
    if (reset) begin
      key_q      <= '0;
      coin_raw_q <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
    end else begin
      key_q      <= key_d;
      coin_raw_q <= coin_raw_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_out
    assign right[p]   = out_q[p][0];
    assign left[p]    = out_q[p][1];
    assign down[p]    = out_q[p][2];
    assign up[p]      = out_q[p][3];
    assign buttons[BUTTONS*p +: BUTTONS] = out_q[p][4 +: BUTTONS];
    assign start[p]   = out_q[p][4+BUTTONS];
    assign coin[p]    = out_q[p][5+BUTTONS];
    assign pause[p]   = out_q[p][6+BUTTONS];
    assign service[p] = out_q[p][7+BUTTONS];
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed steps then random traffic
// against a keymap/coin-window reference model.
module tb_arcade_input_ctrl;

  localparam int P = 3;
  localparam int B = 4;
  localparam int C = 8;
  localparam int W = 8 + B;

  logic             clock = 1'b0;
  logic             reset;
  logic [10:0]      ps2_key;
  logic [32*P-1:0]  joystick;
  logic [P-1:0]     up, down, left, right, start, coin, pause, service;
  logic [B*P-1:0]   buttons;
`ifdef AUTOFIRE_EN
  logic [B*P-1:0]   autofire_mask;
  int               afn;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mkey [2];
  logic [W-1:0] mexp [P];
  logic         mprev [P];
  int           mlast [P];
  logic         mtog;
  int           ncyc = 0;

  logic [7:0] pool [30] = '{
    8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12, 8'h1A, 8'h22,
    8'h16, 8'h2E, 8'h4D, 8'h46, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
    8'h15, 8'h1D, 8'h24, 8'h2C, 8'h1E, 8'h36, 8'h45, 8'h00, 8'h5A, 8'h76};

  arcade_input_ctrl #(
    .PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(C)
`ifdef AUTOFIRE_EN
    , .AUTOFIRE_DIV(4)
`endif
  ) dut (
    .clock(clock), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
`ifdef AUTOFIRE_EN
    .autofire_mask(autofire_mask),
`endif
    .up(up), .down(down), .left(left), .right(right), .buttons(buttons),
    .start(start), .coin(coin), .pause(pause), .service(service)
  );

  always #5 clock = ~clock;

  function automatic int btn(input int k);
    return (k < B) ? 4 + k : -1;
  endfunction

  // key map: returns joystick-bit position of the control, or -1
  function automatic int kmap(input logic [7:0] c, input logic e, output int pl);
    int r;
    int md;
    r = -1; md = 0; pl = 0;
    case (c)
      8'h75: begin r = 3; md = 1; end
      8'h72: begin r = 2; md = 1; end
      8'h6B: begin r = 1; md = 1; end
      8'h74: begin r = 0; md = 1; end
      8'h14: begin r = btn(0); md = 2; end
      8'h11: begin r = btn(1); md = 2; end
      8'h29: r = btn(2);
      8'h12: r = btn(3);
      8'h1A: r = btn(4);
      8'h22: r = btn(5);
      8'h16: r = 4 + B;
      8'h2E: r = 5 + B;
      8'h4D: r = 6 + B;
      8'h46: r = 7 + B;
      default: begin
        pl = 1;
        case (c)
          8'h2D: r = 3;
          8'h2B: r = 2;
          8'h23: r = 1;
          8'h34: r = 0;
          8'h1C: r = btn(0);
          8'h1B: r = btn(1);
          8'h15: r = btn(2);
          8'h1D: r = btn(3);
          8'h24: r = btn(4);
          8'h2C: r = btn(5);
          8'h1E: r = 4 + B;
          8'h36: r = 5 + B;
          8'h45: r = 7 + B;
          default: r = -1;
        endcase
      end
    endcase
    if ((md == 0 && e) || (md == 1 && !e)) r = -1;
    return r;
  endfunction

  task automatic model_edge();
    logic [W-1:0] rw;
    int pl;
    int r;
    if (reset) begin
      for (int p = 0; p < 2; p++) mkey[p] = '0;
      for (int p = 0; p < P; p++) begin
        mexp[p] = '0; mprev[p] = 1'b0; mlast[p] = -100000;
      end
`ifdef AUTOFIRE_EN
      afn = 0;
`endif
    end else begin
`ifdef AUTOFIRE_EN
      afn++;
`endif
      for (int p = 0; p < P; p++) begin
        rw = joystick[32*p +: W];
        if (p < 2) rw = rw | mkey[p];
        if (rw[5+B] && !mprev[p]) mlast[p] = ncyc;
        mprev[p] = rw[5+B];
        mexp[p] = rw;
        mexp[p][5+B] = (ncyc - mlast[p]) < C;
`ifdef AUTOFIRE_EN
        for (int k = 0; k < B; k++)
          if (autofire_mask[B*p+k])
            mexp[p][4+k] = rw[4+k] & (((afn - 1) / 4) % 2 == 1);
`endif
      end
      if (ps2_key[10] != mtog) begin
        r = kmap(ps2_key[7:0], ps2_key[8], pl);
        if (r >= 0) mkey[pl][r] = ps2_key[9];
      end
    end
    mtog = ps2_key[10];
    ncyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, ncyc);
    end
  endtask

  task automatic check_all();
    logic [P-1:0]   eu, ed, el, er, es, ec, ep, ev;
    logic [B*P-1:0] eb;
    for (int p = 0; p < P; p++) begin
      er[p] = mexp[p][0];
      el[p] = mexp[p][1];
      ed[p] = mexp[p][2];
      eu[p] = mexp[p][3];
      eb[B*p +: B] = mexp[p][4 +: B];
      es[p] = mexp[p][4+B];
      ec[p] = mexp[p][5+B];
      ep[p] = mexp[p][6+B];
      ev[p] = mexp[p][7+B];
    end
    chk("up", 32'(up), 32'(eu));
    chk("down", 32'(down), 32'(ed));
    chk("left", 32'(left), 32'(el));
    chk("right", 32'(right), 32'(er));
    chk("buttons", 32'(buttons), 32'(eb));
    chk("start", 32'(start), 32'(es));
    chk("coin", 32'(coin), 32'(ec));
    chk("pause", 32'(pause), 32'(ep));
    chk("service", 32'(service), 32'(ev));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ps2ev(input logic pr, input logic ex, input logic [7:0] c);
    ps2_key = {~ps2_key[10], pr, ex, c};
  endtask

  initial begin
    int hi;
    reset    = 1'b1;
    ps2_key  = 11'h400;
    joystick = '0;
    mtog     = 1'b0;
`ifdef AUTOFIRE_EN
    autofire_mask = 1;
    afn = 0;
`endif
    repeat (3) cyc();
    reset = 1'b0;
    repeat (10) cyc();
    chk("rst_all", 32'({up, down, left, right, buttons, start, coin}), 32'd0);

    ps2ev(1'b1, 1'b1, 8'h75);
    cyc();
    chk("up0_lat1", 32'(up[0]), 32'd0);
    cyc();
    chk("up0_lat2", 32'(up[0]), 32'd1);
    ps2ev(1'b0, 1'b1, 8'h75);
    repeat (2) cyc();
    chk("up0_rel", 32'(up[0]), 32'd0);
    ps2ev(1'b1, 1'b0, 8'h75);
    repeat (2) cyc();
    chk("up0_noext", 32'(up[0]), 32'd0);

    joystick[32+4] = 1'b1;
    cyc();
    chk("joy_b1", 32'(buttons[B]), 32'd1);
    ps2ev(1'b1, 1'b0, 8'h1C);
    cyc();
    joystick[32+4] = 1'b0;
    repeat (3) cyc();
    chk("kb_hold", 32'(buttons[B]), 32'd1);
    ps2ev(1'b0, 1'b0, 8'h1C);
    cyc();
    chk("kb_rel1", 32'(buttons[B]), 32'd1);
    cyc();
    chk("kb_rel2", 32'(buttons[B]), 32'd0);

    ps2ev(1'b1, 1'b0, 8'h2C);
    repeat (2) cyc();
    ps2ev(1'b1, 1'b0, 8'h24);
    repeat (2) cyc();
    chk("undecoded_btn", 32'(buttons), 32'd0);
    joystick[64+3] = 1'b1;
    cyc();
    chk("p2_joy_up", 32'(up), 32'b100);
    joystick[64+3] = 1'b0;
    cyc();

    hi = 0;
    joystick[5+B] = 1'b1;
    cyc();
    hi += coin[0];
    joystick[5+B] = 1'b0;
    repeat (12) begin cyc(); hi += coin[0]; end
    chk("coin_width", 32'(hi), 32'(C));

    hi = 0;
    for (int i = 0; i < 20; i++) begin
      joystick[5+B] = (i == 0 || i == 5);
      cyc();
      hi += coin[0];
    end
    chk("coin_retrig", 32'(hi), 32'd13);

    joystick[5+B] = 1'b1;
    repeat (20) cyc();
    chk("coin_held", 32'(coin[0]), 32'd0);
    joystick[5+B] = 1'b0;
    cyc();

    joystick[5+B] = 1'b1;
    cyc();
    joystick[5+B] = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    ps2ev(1'b1, 1'b1, 8'h72);
    cyc();
    chk("coin_rst", 32'(coin[0]), 32'd0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("rst_evt_prio", 32'(down[0]), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        ps2ev(1'($urandom), 1'($urandom), pool[$urandom_range(0, 29)]);
      else
        ps2_key[9:0] = 10'($urandom);
      if ($urandom_range(0, 2) == 0)
        joystick[$urandom_range(0, 32*P-1)] ^= 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
